// File: rtl/fft_r22sdf_reorder_pkg.sv
// Shared constants and types for the FFT output reorder block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_r22sdf_reorder_pkg;

    localparam int N_DEF      = 1024;
    localparam int N_LOG2_DEF = 10;
    localparam int DW_DEF     = 25;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // When both banks hold a frame, the older one is the bank the writer is
    // pointing at again (it has toggled twice since that frame completed).
    function automatic logic oldest_full(input logic [1:0] full, input logic wr_bank);
        return (&full) ? wr_bank : full[1];
    endfunction

endpackage

// File: rtl/fft_r22sdf_reorder_if.sv
// Stream bundle between the FFT core, the reorder block and the spectral consumer.
// Latency: n/a (wiring only).
// Backpressure: input side has none (sync_i only); output side uses valid_o/ready_i.
interface fft_r22sdf_reorder_if
    import fft_r22sdf_reorder_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DW     = DW_DEF
);
    logic              sync_i;
    logic [N_LOG2-1:0] data_ctr_i;
    logic [DW-1:0]     data_re_i;
    logic [DW-1:0]     data_im_i;
    logic              ready_i;
    logic              valid_o;
    logic [N_LOG2-1:0] bin_o;
    logic [DW-1:0]     data_re_o;
    logic [DW-1:0]     data_im_o;
    logic              last_o;
    logic              overrun_o;

    // Side seen by the reorder block itself.
    modport slave (
        input  sync_i, data_ctr_i, data_re_i, data_im_i, ready_i,
        output valid_o, bin_o, data_re_o, data_im_o, last_o, overrun_o
    );

    // Side seen by whatever drives the FFT stream and consumes the bins.
    modport master (
        output sync_i, data_ctr_i, data_re_i, data_im_i, ready_i,
        input  valid_o, bin_o, data_re_o, data_im_o, last_o, overrun_o
    );
endinterface

// File: rtl/fft_r22sdf_reorder_bank_ram.sv
// Simple dual-port frame store, address {bank, idx}; one write and one read port.
// Latency: write visible next cycle; read data registered one cycle after rd_en.
// Backpressure: none; read register holds its value while rd_en is low.
module fft_reorder_bank_ram #(
    parameter int AW = 11,
    parameter int W  = 50
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);
    logic [W-1:0] mem [2**AW];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    // Registered read; holding on !rd_en lets it act as the stalled output stage.
    always_ff @(posedge clk_i) begin
        if (rd_en) rd_dat <= mem[rd_addr];
    end
endmodule

// File: rtl/fft_r22sdf_reorder.sv
// Reorders each bit-reversed FFT frame into natural bin order via a ping-pong bank store.
// Latency: last input sample at edge t -> first output (bin 0) valid at edge t+2.
// Backpressure: ready_i stalls the read side; a frame that finds no free bank is dropped (overrun_o).
module fft_r22sdf_reorder
    import fft_r22sdf_reorder_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fft_r22sdf_reorder_if.slave  io
);
    localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

    // Writer state
    logic              wr_bank;
    logic [N_LOG2-1:0] wr_cnt;
    logic              drop_r;
    logic              overrun_r;
    logic              wr_busy, wr_drop, wr_done, ram_we;

    // Bank ownership
    logic [1:0]        full, full_set, full_clr;

    // Reader state
    rd_state_t         rd_state;
    logic              rd_bank;
    logic [N_LOG2-1:0] rd_addr;
    logic              valid_r, last_r;
    logic [N_LOG2-1:0] bin_r;
    logic              can_issue, rd_issue, rd_last_issue;
    logic [2*DW-1:0]   ram_q;

    // The drop decision is taken on the first sample of a frame: if the target
    // bank still holds an undrained frame the whole frame is discarded, so a
    // stalled reader never sees its bank overwritten. A bank released by the
    // reader in the same cycle counts as free.
    assign wr_busy  = full[wr_bank] && !full_clr[wr_bank];
    assign wr_drop  = (wr_cnt == '0) ? wr_busy : drop_r;
    assign wr_done  = io.sync_i && (wr_cnt == LAST_IDX);
    assign ram_we   = io.sync_i && !wr_drop;
    assign full_set = (wr_done && !wr_drop) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

    // A read is issued whenever the output stage is empty or being accepted.
    // The bank is released as soon as its last word is read into the output
    // register, which keeps continuous input free of overruns.
    assign can_issue     = !valid_r || io.ready_i;
    assign rd_issue      = (rd_state == RD_READ) && can_issue;
    assign rd_last_issue = rd_issue && (rd_addr == LAST_IDX);
    assign full_clr      = rd_last_issue ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // Writer: frame counting, abandon on sync gap, bank toggle or drop on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            drop_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if (io.sync_i) begin
            drop_r <= wr_drop;
            if (wr_done) begin
                wr_cnt <= '0;
                if (wr_drop) overrun_r <= 1'b1;
                else         wr_bank   <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end else begin
            wr_cnt <= '0;
        end
    end

    // Bank-full flags: set by writer completion, cleared by the reader; both may act at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) full <= 2'b00;
        else       full <= (full & ~full_clr) | full_set;
    end

    // Reader FSM and output stage flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= RD_IDLE;
            rd_bank  <= 1'b0;
            rd_addr  <= '0;
            valid_r  <= 1'b0;
            bin_r    <= '0;
            last_r   <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (|full) begin
                        rd_bank  <= oldest_full(full, wr_bank);
                        rd_addr  <= '0;
                        rd_state <= RD_READ;
                    end
                end
                RD_READ: begin
                    if (rd_issue) begin
                        if (rd_addr == LAST_IDX) begin
                            rd_addr <= '0;
                            if (full[!rd_bank]) rd_bank  <= ~rd_bank;
                            else                rd_state <= RD_IDLE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase

            if (rd_issue) begin
                valid_r <= 1'b1;
                bin_r   <= rd_addr;
                last_r  <= (rd_addr == LAST_IDX);
            end else if (io.ready_i) begin
                valid_r <= 1'b0;
            end
        end
    end

    fft_reorder_bank_ram #(
        .AW (N_LOG2 + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_we),
        .wr_addr ({wr_bank, io.data_ctr_i}),
        .wr_dat  ({io.data_re_i, io.data_im_i}),
        .rd_en   (rd_issue),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_dat  (ram_q)
    );

    // Data is gated by valid so it reads as zero whenever no sample is presented,
    // including immediately on reset assertion.
    assign io.valid_o   = valid_r;
    assign io.bin_o     = bin_r;
    assign io.last_o    = last_r;
    assign io.data_re_o = valid_r ? ram_q[2*DW-1:DW] : '0;
    assign io.data_im_o = valid_r ? ram_q[DW-1:0]    : '0;
    assign io.overrun_o = overrun_r;
endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Scoreboard bench for the FFT reorder block at N=16.
// Latency: checks bin 0 two edges after the last input sample.
// Backpressure: drives ready_i held, toggling and random patterns.
module tb_fft_r22sdf_reorder;
    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [NL-1:0] bin;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_r22sdf_reorder_if #(.N_LOG2(NL), .DW(DW)) bus();

    fft_r22sdf_reorder #(.N(N), .N_LOG2(NL), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rdy_mode = 0;          // 0: ready=1, 1: ready=0, 2: toggle, 3: random
    int last_edge = 0;
    smp_t exp_q[$];
    int   acc_log[$];

    logic [NL-1:0] ctr_a [N];
    logic [DW-1:0] re_a  [N];
    logic [DW-1:0] im_a  [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [NL-1:0] bitrev(input int v);
        logic [NL-1:0] x, r;
        x = NL'(v);
        for (int k = 0; k < NL; k++) r[k] = x[NL-1-k];
        return r;
    endfunction

    // Frame in FFT delivery order; ramp frames carry re=bin, im=-bin.
    task automatic gen_frame(input bit ramp);
        for (int i = 0; i < N; i++) begin
            ctr_a[i] = bitrev(i);
            if (ramp) begin
                re_a[i] = DW'(int'(ctr_a[i]));
                im_a[i] = DW'(-int'(ctr_a[i]));
            end else begin
                re_a[i] = DW'($urandom);
                im_a[i] = DW'($urandom);
            end
        end
    endtask

    // Reference: the frame re-indexed by bin, emitted 0..N-1.
    task automatic push_expected();
        logic [DW-1:0] mre [N];
        logic [DW-1:0] mim [N];
        smp_t e;
        for (int i = 0; i < N; i++) begin
            mre[ctr_a[i]] = re_a[i];
            mim[ctr_a[i]] = im_a[i];
        end
        for (int b = 0; b < N; b++) begin
            e.bin  = NL'(b);
            e.re   = mre[b];
            e.im   = mim[b];
            e.last = (b == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame(input int cnt, input bit expect_out);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            bus.sync_i     = 1'b1;
            bus.data_ctr_i = ctr_a[i];
            bus.data_re_i  = re_a[i];
            bus.data_im_i  = im_a[i];
        end
        last_edge = cyc + 1;
        if (expect_out) push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.sync_i     = 1'b0;
            bus.data_ctr_i = NL'($urandom);
            bus.data_re_i  = DW'($urandom);
            bus.data_im_i  = DW'($urandom);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.valid_o) done = 1'b1;
        end
        check(name, done, 64'(exp_q.size()), 64'd0);
    endtask

    // Ready pattern generator.
    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.ready_i = 1'b1;
                1:       bus.ready_i = 1'b0;
                2:       bus.ready_i = ~bus.ready_i;
                default: bus.ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare every accepted sample against the scoreboard, and
    // require the presented sample to stay put while stalled.
    smp_t cur, held, e_pop;
    bit   held_v = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            cur.bin  = bus.bin_o;
            cur.re   = bus.data_re_o;
            cur.im   = bus.data_im_o;
            cur.last = bus.last_o;
            if (rst || !bus.valid_o) begin
                held_v = 1'b0;
            end else begin
                if (held_v) check("stall_hold", cur == held, 64'(cur), 64'(held));
                if (bus.ready_i) begin
                    acc_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1'b0, 64'(cur), 64'd0);
                    end else begin
                        e_pop = exp_q.pop_front();
                        check("out_sample", cur == e_pop, 64'(cur), 64'(e_pop));
                    end
                    held_v = 1'b0;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  found;
        bus.sync_i     = 1'b0;
        bus.data_ctr_i = '0;
        bus.data_re_i  = '0;
        bus.data_im_i  = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid",   bus.valid_o == 1'b0,   64'(bus.valid_o),   64'd0);
        check("rst_bin",     bus.bin_o == '0,       64'(bus.bin_o),     64'd0);
        check("rst_re",      bus.data_re_o == '0,   64'(bus.data_re_o), 64'd0);
        check("rst_im",      bus.data_im_o == '0,   64'(bus.data_im_o), 64'd0);
        check("rst_last",    bus.last_o == 1'b0,    64'(bus.last_o),    64'd0);
        check("rst_overrun", bus.overrun_o == 1'b0, 64'(bus.overrun_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single ramp frame, latency and count.
        gen_frame(1'b1);
        base = acc_log.size();
        drive_frame(N, 1'b1);
        idle(1);
        wait_drain("t1_drain");
        check("t1_count", acc_log.size() - base == N, 64'(acc_log.size() - base), 64'(N));
        check("t1_latency", acc_log.size() > base && acc_log[base] - last_edge == 2,
              64'(acc_log.size() > base ? acc_log[base] - last_edge : -1), 64'd2);

        // Three back-to-back frames: 48 contiguous outputs.
        base = acc_log.size();
        for (int f = 0; f < 3; f++) begin
            gen_frame(1'b0);
            drive_frame(N, 1'b1);
        end
        idle(1);
        wait_drain("t2_drain");
        check("t2_count", acc_log.size() - base == 3 * N, 64'(acc_log.size() - base), 64'(3 * N));
        check("t2_no_gap", acc_log.size() >= base + 3 * N && acc_log[base + 3*N - 1] - acc_log[base] == 3 * N - 1,
              64'(acc_log.size() >= base + 3 * N ? acc_log[base + 3*N - 1] - acc_log[base] : -1), 64'(3 * N - 1));
        check("t2_overrun", bus.overrun_o == 1'b0, 64'(bus.overrun_o), 64'd0);

        // Toggling ready.
        rdy_mode = 2;
        gen_frame(1'b0);
        drive_frame(N, 1'b1);
        idle(1);
        wait_drain("t4_drain");
        rdy_mode = 0;

        // Abandoned partial frame followed by a full frame.
        gen_frame(1'b0);
        drive_frame(5, 1'b0);
        idle(1);
        gen_frame(1'b0);
        drive_frame(N, 1'b1);
        idle(1);
        wait_drain("t5_drain");
        check("t5_overrun", bus.overrun_o == 1'b0, 64'(bus.overrun_o), 64'd0);

        // Downstream stalled while three frames arrive: third is dropped.
        rdy_mode = 1;
        idle(2);
        gen_frame(1'b0); drive_frame(N, 1'b1);
        gen_frame(1'b0); drive_frame(N, 1'b1);
        gen_frame(1'b0); drive_frame(N, 1'b0);
        idle(3);
        check("t3_overrun_set", bus.overrun_o == 1'b1, 64'(bus.overrun_o), 64'd1);
        check("t3_stall_bin0", bus.valid_o == 1'b1 && bus.bin_o == '0,
              64'({bus.valid_o, bus.bin_o}), 64'({1'b1, NL'(0)}));
        rdy_mode = 0;
        wait_drain("t3_drain");
        check("t3_overrun_sticky", bus.overrun_o == 1'b1, 64'(bus.overrun_o), 64'd1);

        // Reset while bin 7 is presented.
        gen_frame(1'b0);
        drive_frame(N, 1'b1);
        idle(1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.valid_o && bus.bin_o == NL'(7)) found = 1'b1;
        end
        check("t6_reach_bin7", found, 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_outputs",
              {bus.valid_o, bus.bin_o, bus.data_re_o, bus.data_im_o, bus.last_o} == '0,
              64'({bus.valid_o, bus.bin_o, bus.data_re_o, bus.data_im_o, bus.last_o}), 64'd0);
        check("t6_rst_overrun", bus.overrun_o == 1'b0, 64'(bus.overrun_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 3;
        idle(2);
        gen_frame(1'b0);
        drive_frame(N, 1'b1);
        idle(1);
        wait_drain("t6_drain");
        check("t6_overrun", bus.overrun_o == 1'b0, 64'(bus.overrun_o), 64'd0);
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
